// File: rtl/csi_pll_supervisor.sv
`timescale 1ns/1ps
// Clock/reset supervisor for the CSI receive PLL: reset sequencing, lock debounce,
// byte-clock frequency check and per-lane reset release. Optional: CSI_PLL_REMEASURE_EN.
module csi_pll_supervisor #(
  parameter int unsigned LANES           = 2,
  parameter int unsigned DESER_WIDTH     = 8,
  parameter int unsigned RST_HOLD_CYC    = 16,
  parameter int unsigned LOCK_STABLE_CYC = 1024,
  parameter int unsigned LOCK_TIMEOUT    = 65535,
  parameter int unsigned MEAS_WIN        = 1024,
  parameter int unsigned EXP_CNT         = 512,
  parameter int unsigned TOL             = 8,
  parameter int unsigned MAX_RETRY       = 7
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             pll_lock,
  input  logic             div_toggle,
  output logic             pll_reset,
  output logic [LANES-1:0] lane_rst,
  output logic             ready,
  output logic             fail,
  output logic [3:0]       retry_cnt,
  output logic [15:0]      meas_cnt,
  output logic [2:0]       state,
  output logic [3:0]       cfg_width
);

  typedef enum logic [2:0] {
    ST_RESET_PLL  = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_MEASURE    = 3'd2,
    ST_RELEASE    = 3'd3,
    ST_RUN        = 3'd4,
    ST_FAIL       = 3'd5
  } state_e;

  localparam logic [15:0] HOLD_LAST    = 16'(RST_HOLD_CYC - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(LOCK_STABLE_CYC - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] WIN_LAST     = 16'(MEAS_WIN - 1);
  localparam logic [15:0] LANE_LAST    = 16'(LANES - 1);
  localparam logic [15:0] EXP16        = 16'(EXP_CNT);
  localparam logic [15:0] TOL16        = 16'(TOL);
  localparam logic [3:0]  MAX_RETRY4   = 4'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [1:0]  lock_sync_q, tog_sync_q;
  logic        tog_prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] stable_q, stable_d;
  logic [15:0] edge_cnt_q, edge_cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic [15:0] meas_q, meas_d;

  logic        lock_s, tog_edge, in_tol, do_retry;
  logic [15:0] edge_sum, diff;

  assign lock_s   = lock_sync_q[1];
  assign tog_edge = tog_sync_q[1] ^ tog_prev_q;
  assign edge_sum = (tog_edge && edge_cnt_q != 16'hFFFF) ? edge_cnt_q + 16'd1 : edge_cnt_q;
  assign diff     = (edge_sum >= EXP16) ? edge_sum - EXP16 : EXP16 - edge_sum;
  assign in_tol   = diff <= TOL16;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= ST_RESET_PLL;
      lock_sync_q <= '0;
      tog_sync_q  <= '0;
      tog_prev_q  <= 1'b0;
      cnt_q       <= '0;
      stable_q    <= '0;
      edge_cnt_q  <= '0;
      retry_q     <= '0;
      meas_q      <= '0;
    end else begin
      state_q     <= state_d;
      lock_sync_q <= {lock_sync_q[0], pll_lock};
      tog_sync_q  <= {tog_sync_q[0], div_toggle};
      tog_prev_q  <= tog_sync_q[1];
      cnt_q       <= cnt_d;
      stable_q    <= stable_d;
      edge_cnt_q  <= edge_cnt_d;
      retry_q     <= retry_d;
      meas_q      <= meas_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    stable_d   = '0;
    edge_cnt_d = edge_sum;
    retry_d    = retry_q;
    meas_d     = meas_q;
    do_retry   = 1'b0;
    unique case (state_q)
      ST_RESET_PLL: if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        stable_d = lock_s ? stable_q + 16'd1 : 16'd0;
        if (lock_s && stable_q == STABLE_LAST) state_d = ST_MEASURE;
        else if (cnt_q == TIMEOUT_LAST)        do_retry = 1'b1;
      end
      ST_MEASURE: begin
        if (!lock_s) do_retry = 1'b1;
        else if (cnt_q == WIN_LAST) begin
          meas_d = edge_sum;
          if (in_tol) state_d = ST_RELEASE;
          else        do_retry = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!lock_s)                 do_retry = 1'b1;
        else if (cnt_q == LANE_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Lock loss here is a recovery, not a failed attempt: retry_cnt is left alone.
        if (!lock_s) state_d = ST_RESET_PLL;
`ifdef CSI_PLL_REMEASURE_EN
        else if (cnt_q == WIN_LAST) begin
          meas_d     = edge_sum;
          cnt_d      = '0;
          edge_cnt_d = '0;
          if (!in_tol) do_retry = 1'b1;
        end
`endif
      end
      ST_FAIL: cnt_d = cnt_q;
      default: state_d = ST_RESET_PLL;
    endcase

    if (do_retry) begin
      retry_d = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;
      state_d = (retry_d >= MAX_RETRY4) ? ST_FAIL : ST_RESET_PLL;
    end
    // Each state starts with fresh cycle, debounce and edge counters.
    if (state_d != state_q) begin
      cnt_d      = '0;
      stable_d   = '0;
      edge_cnt_d = '0;
    end
  end

  always_comb begin
    lane_rst = '1;
    if (state_q == ST_RELEASE) begin
      for (int j = 0; j < LANES; j++) lane_rst[j] = 16'(j) > cnt_q;
    end else if (state_q == ST_RUN) begin
      lane_rst = '0;
    end
  end

  assign pll_reset = (state_q == ST_RESET_PLL) || (state_q == ST_FAIL);
  assign ready     = state_q == ST_RUN;
  assign fail      = state_q == ST_FAIL;
  assign retry_cnt = retry_q;
  assign meas_cnt  = meas_q;
  assign state     = state_q;
  assign cfg_width = 4'(DESER_WIDTH);

endmodule
